// File: rtl/tb_min_state_search_if.sv
// Handshake bundle between the path-metric read-out, the minimum-state search
// and the traceback controller.
interface tb_min_state_search_if #(
  parameter int M     = 3,
  parameter int W     = 8,
  parameter int LANES = 2
) ();
  logic               in_valid;
  logic               in_ready;
  logic               in_first;
  logic [LANES*W-1:0] in_metrics;
  logic               out_valid;
  logic               out_ready;
  logic [M-1:0]       best_state;
  logic [W-1:0]       min_metric;
  logic               norm_req;
  logic               seq_err;

  modport master (
    output in_valid, in_first, in_metrics, out_ready,
    input  in_ready, out_valid, best_state, min_metric, norm_req, seq_err
  );

  modport slave (
    input  in_valid, in_first, in_metrics, out_ready,
    output in_ready, out_valid, best_state, min_metric, norm_req, seq_err
  );
endinterface

// File: rtl/tb_min_state_search.sv
// Sequential minimum-path-metric search over 2^M trellis states, LANES metrics
// per beat; yields the traceback start state, its metric and a normalisation request.
module tb_min_state_search #(
  parameter int M           = 3,
  parameter int W           = 8,
  parameter int LANES       = 2,
  parameter int NORM_THRESH = 128
) (
  input logic                  clk,
  input logic                  rst,
  tb_min_state_search_if.slave bus
);
  localparam int N     = 1 << M;
  localparam int BEATS = N / LANES;
  localparam int CNT_W = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  typedef struct packed {
    logic [W-1:0] val;
    logic [M-1:0] lane;
  } lane_min_t;

  // Lowest lane wins ties because later lanes need a strictly smaller value.
  function automatic lane_min_t beat_min(input logic [LANES*W-1:0] metrics);
    lane_min_t res;
    res.val  = metrics[W-1:0];
    res.lane = {M{1'b0}};
    for (int j = 1; j < LANES; j++) begin
      if (metrics[j*W +: W] < res.val) begin
        res.val  = metrics[j*W +: W];
        res.lane = M'(j);
      end
    end
    return res;
  endfunction

  function automatic logic norm_check(input logic [W-1:0] metric);
    return (32'(metric) >= 32'(NORM_THRESH));
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     run_min_q, run_min_d;
  logic [M-1:0]     run_idx_q, run_idx_d;
  logic [M-1:0]     best_q, best_d;
  logic [W-1:0]     metric_q, metric_d;
  logic             norm_q, norm_d;
  logic             seq_err_q, seq_err_d;
  logic             in_ready_q;
  logic             out_valid_q;

  lane_min_t        beat_s;
  logic [CNT_W-1:0] beat_base_s;
  logic [M-1:0]     beat_idx_s;
  logic [W-1:0]     merged_min_s;
  logic [M-1:0]     merged_idx_s;
  logic             accept_s;

  assign accept_s = bus.in_valid && in_ready_q;

  // Beat minimum and its global state index; in_first always means beat 0.
  always_comb begin
    beat_s = beat_min(bus.in_metrics);
    if (bus.in_first) begin
      beat_base_s = {CNT_W{1'b0}};
    end else begin
      beat_base_s = cnt_q;
    end
    beat_idx_s = M'(32'(beat_base_s) * 32'(LANES) + 32'(beat_s.lane));
  end

  // Running minimum only moves on a strictly smaller beat minimum.
  always_comb begin
    if (beat_s.val < run_min_q) begin
      merged_min_s = beat_s.val;
      merged_idx_s = beat_idx_s;
    end else begin
      merged_min_s = run_min_q;
      merged_idx_s = run_idx_q;
    end
  end

  // Next-state and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    run_idx_d = run_idx_q;
    best_d    = best_q;
    metric_d  = metric_q;
    norm_d    = norm_q;
    seq_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s && bus.in_first) begin
          run_min_d = beat_s.val;
          run_idx_d = beat_idx_s;
          if (BEATS == 1) begin
            state_d  = S_HOLD;
            cnt_d    = {CNT_W{1'b0}};
            best_d   = beat_idx_s;
            metric_d = beat_s.val;
            norm_d   = norm_check(beat_s.val);
          end else begin
            state_d = S_ACCUM;
            cnt_d   = CNT_W'(1);
          end
        end else if (accept_s) begin
          seq_err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (accept_s && bus.in_first) begin
          seq_err_d = 1'b1;
          run_min_d = beat_s.val;
          run_idx_d = beat_idx_s;
          cnt_d     = CNT_W'(1);
        end else if (accept_s) begin
          run_min_d = merged_min_s;
          run_idx_d = merged_idx_s;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d  = S_HOLD;
            cnt_d    = {CNT_W{1'b0}};
            best_d   = merged_idx_s;
            metric_d = merged_min_s;
            norm_d   = norm_check(merged_min_s);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, running search and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      run_min_q   <= {W{1'b0}};
      run_idx_q   <= {M{1'b0}};
      best_q      <= {M{1'b0}};
      metric_q    <= {W{1'b0}};
      norm_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_min_q   <= run_min_d;
      run_idx_q   <= run_idx_d;
      best_q      <= best_d;
      metric_q    <= metric_d;
      norm_q      <= norm_d;
      seq_err_q   <= seq_err_d;
      in_ready_q  <= (state_d != S_HOLD);
      out_valid_q <= (state_d == S_HOLD);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.best_state = best_q;
  assign bus.min_metric = metric_q;
  assign bus.norm_req   = norm_q;
  assign bus.seq_err    = seq_err_q;
endmodule

// File: tb/tb_tb_min_state_search.sv
// Bench for the minimum-state search: directed cases plus random vectors
// against a lowest-index-minimum reference, on LANES = 2, 1 and 8.
module tb_tb_min_state_search;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  typedef logic [7:0] vec_t [8];

  always #5 clk = ~clk;

  tb_min_state_search_if #(.M(3), .W(8), .LANES(2)) b2 ();
  tb_min_state_search_if #(.M(3), .W(8), .LANES(1)) b1 ();
  tb_min_state_search_if #(.M(3), .W(8), .LANES(8)) b8 ();

  tb_min_state_search #(.M(3), .W(8), .LANES(2), .NORM_THRESH(128)) u2 (.clk(clk), .rst(rst), .bus(b2));
  tb_min_state_search #(.M(3), .W(8), .LANES(1), .NORM_THRESH(128)) u1 (.clk(clk), .rst(rst), .bus(b1));
  tb_min_state_search #(.M(3), .W(8), .LANES(8), .NORM_THRESH(128)) u8 (.clk(clk), .rst(rst), .bus(b8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first (lowest-index) state holding the smallest metric.
  function automatic void ref_min(input vec_t v, output int idx, output int mn);
    idx = 0;
    mn  = int'(v[0]);
    for (int i = 1; i < 8; i++) begin
      if (int'(v[i]) < mn) begin
        mn  = int'(v[i]);
        idx = i;
      end
    end
  endfunction

  task automatic send_vec2(input vec_t v, input bit restart);
    int ei, em;
    for (int b = 0; b < 4; b++) begin
      b2.in_valid   = 1'b1;
      b2.in_first   = (b == 0);
      b2.in_metrics = {v[2*b+1], v[2*b]};
      step();
      if (b == 0) check("seq_err_b0", 32'(b2.seq_err), 32'(restart));
      if (b == 1) check("seq_err_b1", 32'(b2.seq_err), 32'd0);
      if (b == 2) check("early_valid", 32'(b2.out_valid), 32'd0);
    end
    b2.in_valid = 1'b0;
    b2.in_first = 1'b0;
    ref_min(v, ei, em);
    check("l2_valid", 32'(b2.out_valid), 32'd1);
    check("l2_best", 32'(b2.best_state), 32'(ei));
    check("l2_min", 32'(b2.min_metric), 32'(em));
    check("l2_norm", 32'(b2.norm_req), 32'(em >= 128));
  endtask

  task automatic take_result2();
    step();
    check("valid_pulse", 32'(b2.out_valid), 32'd0);
    check("ready_back", 32'(b2.in_ready), 32'd1);
  endtask

  task automatic send_vec1(input vec_t v);
    int ei, em;
    for (int b = 0; b < 8; b++) begin
      b1.in_valid   = 1'b1;
      b1.in_first   = (b == 0);
      b1.in_metrics = v[b];
      step();
      if (b == 6) check("l1_early_valid", 32'(b1.out_valid), 32'd0);
    end
    b1.in_valid = 1'b0;
    b1.in_first = 1'b0;
    ref_min(v, ei, em);
    check("l1_valid", 32'(b1.out_valid), 32'd1);
    check("l1_best", 32'(b1.best_state), 32'(ei));
    check("l1_min", 32'(b1.min_metric), 32'(em));
    step();
    check("l1_pulse", 32'(b1.out_valid), 32'd0);
  endtask

  task automatic send_vec8(input vec_t v);
    int ei, em;
    check("l8_early_valid", 32'(b8.out_valid), 32'd0);
    b8.in_valid = 1'b1;
    b8.in_first = 1'b1;
    for (int i = 0; i < 8; i++) b8.in_metrics[i*8 +: 8] = v[i];
    step();
    b8.in_valid = 1'b0;
    b8.in_first = 1'b0;
    ref_min(v, ei, em);
    check("l8_valid", 32'(b8.out_valid), 32'd1);
    check("l8_best", 32'(b8.best_state), 32'(ei));
    check("l8_min", 32'(b8.min_metric), 32'(em));
    step();
    check("l8_pulse", 32'(b8.out_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] snap_best, snap_min, snap_norm;
    int p, dly;

    rst = 1'b1;
    b2.in_valid = 1'b0; b2.in_first = 1'b0; b2.in_metrics = '0; b2.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_first = 1'b0; b1.in_metrics = '0; b1.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_first = 1'b0; b8.in_metrics = '0; b8.out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(b2.in_ready), 32'd1);
    check("rst_out_valid", 32'(b2.out_valid), 32'd0);
    check("rst_best", 32'(b2.best_state), 32'd0);
    check("rst_min", 32'(b2.min_metric), 32'd0);
    check("rst_norm", 32'(b2.norm_req), 32'd0);
    check("rst_seq_err", 32'(b2.seq_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    v = '{8'd10, 8'd20, 8'd5, 8'd30, 8'd7, 8'd9, 8'd40, 8'd50};
    send_vec2(v, 1'b0);
    check("basic_best", 32'(b2.best_state), 32'd2);
    check("basic_min", 32'(b2.min_metric), 32'd5);
    take_result2();

    v = '{8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17, 8'd17};
    send_vec2(v, 1'b0);
    check("tie_all", 32'(b2.best_state), 32'd0);
    take_result2();
    v = '{8'd9, 8'd3, 8'd8, 8'd8, 8'd8, 8'd8, 8'd3, 8'd8};
    send_vec2(v, 1'b0);
    check("tie_cross", 32'(b2.best_state), 32'd1);
    take_result2();
    v = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd4, 8'd4};
    send_vec2(v, 1'b0);
    check("tie_intra", 32'(b2.best_state), 32'd6);
    take_result2();

    // Backpressure with beats offered while the result is held.
    b2.out_ready = 1'b0;
    v = '{8'd10, 8'd20, 8'd5, 8'd30, 8'd7, 8'd9, 8'd40, 8'd50};
    send_vec2(v, 1'b0);
    snap_best = 32'(b2.best_state);
    snap_min  = 32'(b2.min_metric);
    snap_norm = 32'(b2.norm_req);
    for (int k = 0; k < 5; k++) begin
      b2.in_valid   = 1'b1;
      b2.in_first   = 1'b1;
      b2.in_metrics = 16'h0100;
      step();
      check("bp_valid", 32'(b2.out_valid), 32'd1);
      check("bp_ready", 32'(b2.in_ready), 32'd0);
      check("bp_best", 32'(b2.best_state), snap_best);
      check("bp_min", 32'(b2.min_metric), snap_min);
      check("bp_norm", 32'(b2.norm_req), snap_norm);
      check("bp_seq_err", 32'(b2.seq_err), 32'd0);
    end
    b2.in_valid  = 1'b0;
    b2.in_first  = 1'b0;
    b2.out_ready = 1'b1;
    take_result2();
    v = '{8'd1, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    send_vec2(v, 1'b0);
    check("bp_next_best", 32'(b2.best_state), 32'd1);
    take_result2();

    // Restart in the middle of a vector.
    b2.in_valid = 1'b1; b2.in_first = 1'b1; b2.in_metrics = {8'd60, 8'd50};
    step();
    b2.in_first = 1'b0; b2.in_metrics = {8'd80, 8'd70};
    step();
    v = '{8'd90, 8'd91, 8'd2, 8'd93, 8'd94, 8'd95, 8'd96, 8'd97};
    send_vec2(v, 1'b1);
    check("restart_best", 32'(b2.best_state), 32'd2);
    check("restart_min", 32'(b2.min_metric), 32'd2);
    take_result2();

    // Stray beat without in_first while idle.
    b2.in_valid = 1'b1; b2.in_first = 1'b0; b2.in_metrics = {8'd1, 8'd1};
    step();
    b2.in_valid = 1'b0;
    check("stray_err", 32'(b2.seq_err), 32'd1);
    step();
    check("stray_err_drop", 32'(b2.seq_err), 32'd0);
    check("stray_no_out", 32'(b2.out_valid), 32'd0);

    for (int i = 0; i < 7; i++) v[i] = 8'($urandom_range(201, 255));
    v[7] = 8'd200;
    send_vec2(v, 1'b0);
    check("norm_best", 32'(b2.best_state), 32'd7);
    check("norm_hi", 32'(b2.norm_req), 32'd1);
    take_result2();
    for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(128, 255));
    p = int'($urandom_range(0, 7));
    v[p] = 8'd127;
    send_vec2(v, 1'b0);
    check("norm_lo", 32'(b2.norm_req), 32'd0);
    take_result2();

    // Reset while holding a result.
    b2.out_ready = 1'b0;
    v = '{8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99, 8'd22};
    send_vec2(v, 1'b0);
    rst = 1'b1;
    #1;
    check("rsthold_valid", 32'(b2.out_valid), 32'd0);
    check("rsthold_ready", 32'(b2.in_ready), 32'd1);
    check("rsthold_best", 32'(b2.best_state), 32'd0);
    check("rsthold_min", 32'(b2.min_metric), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    b2.out_ready = 1'b1;

    // Reset after three beats of a vector.
    for (int b = 0; b < 3; b++) begin
      b2.in_valid = 1'b1; b2.in_first = (b == 0); b2.in_metrics = {8'd0, 8'd0};
      step();
    end
    b2.in_valid = 1'b0; b2.in_first = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(b2.out_valid), 32'd0);
    check("rstmid_ready", 32'(b2.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    v = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd6, 8'd7};
    send_vec2(v, 1'b0);
    check("rstmid_best", 32'(b2.best_state), 32'd5);
    take_result2();

    // Random vectors with random consumer stalls and idle gaps.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, (t % 2 == 0) ? 15 : 255));
      dly = int'($urandom_range(0, 3));
      b2.out_ready = (dly == 0);
      send_vec2(v, 1'b0);
      for (int k = 0; k < dly; k++) begin
        step();
        check("rnd_hold", 32'(b2.out_valid), 32'd1);
      end
      b2.out_ready = 1'b1;
      take_result2();
      repeat ($urandom_range(0, 2)) step();
    end

    // LANES = 1 and LANES = 8 variants.
    v = '{8'd10, 8'd20, 8'd5, 8'd30, 8'd7, 8'd9, 8'd40, 8'd50};
    send_vec1(v);
    check("l1_basic_best", 32'(b1.best_state), 32'd2);
    send_vec8(v);
    check("l8_basic_best", 32'(b8.best_state), 32'd2);
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, 31));
      send_vec1(v);
      send_vec8(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
